// File: rtl/wb_rr_slave_arbiter.sv
// rtl/wb_rr_slave_arbiter.sv - round-robin arbiter sharing one Wishbone B4 slave between several masters
// Grant is held for the owner's whole CYC tenure; a watchdog converts a stalled strobe into ERR.
module wb_rr_slave_arbiter #(
    parameter int N_MASTERS      = 4,
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int ID_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
    localparam int SEL_W = WB_DATA_WIDTH / 8,
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [N_MASTERS-1:0][WB_ADDR_WIDTH-1:0]      ADR,
    input  logic [N_MASTERS-1:0][2:0]                    CTI,
    input  logic [N_MASTERS-1:0][1:0]                    BTE,
    input  logic [N_MASTERS-1:0][WB_DATA_WIDTH-1:0]      DAT_W,
    output logic [N_MASTERS-1:0][WB_DATA_WIDTH-1:0]      DAT_R,
    input  logic [N_MASTERS-1:0]                         CYC,
    input  logic [N_MASTERS-1:0]                         STB,
    input  logic [N_MASTERS-1:0][SEL_W-1:0]              SEL,
    input  logic [N_MASTERS-1:0]                         WE,
    output logic [N_MASTERS-1:0]                         ACK,
    output logic [N_MASTERS-1:0]                         ERR,
    output logic [WB_ADDR_WIDTH-1:0]                     SADR,
    output logic [2:0]                                   SCTI,
    output logic [1:0]                                   SBTE,
    output logic [WB_DATA_WIDTH-1:0]                     SDAT_W,
    output logic [SEL_W-1:0]                             SSEL,
    output logic                                         SWE,
    output logic                                         SCYC,
    output logic                                         SSTB,
    input  logic [WB_DATA_WIDTH-1:0]                     SDAT_R,
    input  logic                                         SACK,
    input  logic                                         SERR,
    output logic                                         gnt_valid,
    output logic [ID_W-1:0]                              gnt_id,
    output logic                                         timeout
);

    typedef enum logic [1:0] {IDLE, GRANT, TOERR, DRAIN} state_t;

    state_t            state, state_nx;
    logic [ID_W-1:0]   last_id, gnt_q, pick;
    logic              pick_vld;
    logic [CNT_W-1:0]  cnt;
    logic              own_cyc, own_stb, slv_resp, wd_fire, in_grant;

    assign own_cyc  = CYC[gnt_q];
    assign own_stb  = STB[gnt_q];
    assign slv_resp = SACK | SERR;
    assign wd_fire  = own_stb && !slv_resp && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign in_grant = !rst && (state == GRANT);

    // First requester strictly after last_id, wrapping; last_id itself is tried last.
    always_comb begin
        int idx;
        idx      = 0;
        pick_vld = 1'b0;
        pick     = '0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            idx = (int'(last_id) + k) % N_MASTERS;
            if (!pick_vld && CYC[idx]) begin
                pick_vld = 1'b1;
                pick     = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_vld) state_nx = GRANT;
            GRANT:   if (!own_cyc) state_nx = IDLE;
                     else if (wd_fire) state_nx = TOERR;
            TOERR:   state_nx = DRAIN;
            DRAIN:   if (!own_cyc) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last_id <= ID_W'(N_MASTERS - 1);
            gnt_q   <= '0;
            cnt     <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && pick_vld)
                gnt_q <= pick;
            if ((state == GRANT || state == DRAIN) && !own_cyc)
                last_id <= gnt_q;
            // Watchdog only runs while the owner strobes without a slave response.
            if (state != GRANT || slv_resp || !own_stb)
                cnt <= '0;
            else if (cnt != CNT_W'(TIMEOUT_CYCLES - 1))
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        SADR   = '0;
        SCTI   = '0;
        SBTE   = '0;
        SDAT_W = '0;
        SSEL   = '0;
        SWE    = 1'b0;
        SCYC   = 1'b0;
        SSTB   = 1'b0;
        DAT_R  = '0;
        ACK    = '0;
        ERR    = '0;
        if (in_grant) begin
            SADR   = ADR[gnt_q];
            SCTI   = CTI[gnt_q];
            SBTE   = BTE[gnt_q];
            SDAT_W = DAT_W[gnt_q];
            SSEL   = SEL[gnt_q];
            SWE    = WE[gnt_q];
            SCYC   = own_cyc;
            SSTB   = own_stb;
        end
        for (int i = 0; i < N_MASTERS; i++) begin
            if (in_grant && gnt_q == ID_W'(i)) begin
                DAT_R[i] = SDAT_R;
                ACK[i]   = SACK;
                ERR[i]   = SERR;
            end else if (!rst && state == TOERR && gnt_q == ID_W'(i)) begin
                ERR[i] = 1'b1;
            end
        end
    end

    assign gnt_valid = !rst && (state != IDLE);
    assign gnt_id    = gnt_valid ? gnt_q : '0;
    assign timeout   = !rst && (state == TOERR);

endmodule

// File: tb/tb_wb_rr_slave_arbiter.sv
// tb/tb_wb_rr_slave_arbiter.sv - scoreboard bench for wb_rr_slave_arbiter
module tb_wb_rr_slave_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam logic [31:0] KEY = 32'h5A5A_0000;
    localparam int EV_G = 0;
    localparam int EV_A = 1;
    localparam int EV_E = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0][AW-1:0]   ADR;
    logic [N-1:0][2:0]      CTI;
    logic [N-1:0][1:0]      BTE;
    logic [N-1:0][DW-1:0]   DAT_W;
    logic [N-1:0][DW-1:0]   DAT_R;
    logic [N-1:0]           CYC, STB, WE, ACK, ERR;
    logic [N-1:0][DW/8-1:0] SEL;
    logic [AW-1:0]          SADR;
    logic [2:0]             SCTI;
    logic [1:0]             SBTE;
    logic [DW-1:0]          SDAT_W, SDAT_R;
    logic [DW/8-1:0]        SSEL;
    logic                   SWE, SCYC, SSTB, SACK, SERR;
    logic                   gnt_valid, timeout;
    logic [1:0]             gnt_id;
    logic                   ack_en = 1'b1;
    logic                   late_ack = 1'b0;

    always #5 clk = ~clk;

    // Zero-wait slave: read data is a fixed function of the address.
    assign SACK   = (ack_en & SCYC & SSTB) | late_ack;
    assign SERR   = 1'b0;
    assign SDAT_R = SADR ^ KEY;

    wb_rr_slave_arbiter #(
        .N_MASTERS(N), .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .ADR(ADR), .CTI(CTI), .BTE(BTE), .DAT_W(DAT_W), .DAT_R(DAT_R),
        .CYC(CYC), .STB(STB), .SEL(SEL), .WE(WE), .ACK(ACK), .ERR(ERR),
        .SADR(SADR), .SCTI(SCTI), .SBTE(SBTE), .SDAT_W(SDAT_W), .SSEL(SSEL), .SWE(SWE),
        .SCYC(SCYC), .SSTB(SSTB), .SDAT_R(SDAT_R), .SACK(SACK), .SERR(SERR),
        .gnt_valid(gnt_valid), .gnt_id(gnt_id), .timeout(timeout)
    );

    typedef struct {
        int          kind;
        int          id;
        logic [31:0] data;
    } ev_t;

    ev_t q[$];
    int  n_chk = 0;
    int  n_fail = 0;

    logic [31:0] base [N];
    int          beats [N];
    int          reps [N];
    int          go_cnt [N];
    int          kill_cnt [N];
    logic [N-1:0] rearm = '0;
    logic [N-1:0] err_seen = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int id, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.id   = id;
        e.data = data;
        q.push_back(e);
    endtask

    task automatic get_ev(output ev_t ev, output bit ok);
        ev.kind = -1;
        ev.id   = -1;
        ev.data = '0;
        ok      = 1'b0;
        if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_event: got an output event, expected none pending");
        end else begin
            ev = q.pop_front();
            ok = 1'b1;
        end
    endtask

    task automatic start(input int i, input logic [31:0] b, input int nb, input int nr);
        base[i]  = b;
        beats[i] = nb;
        reps[i]  = nr;
        go_cnt[i]++;
    endtask

    // Master driver: the only writer of the master-side buses.
    initial begin
        logic [N-1:0] a, e;
        int bcnt [N];
        int seen_go [N];
        int seen_kill [N];
        ADR = '0; CTI = '0; BTE = '0; DAT_W = '0; SEL = '1; WE = '0; CYC = '0; STB = '0;
        for (int i = 0; i < N; i++) begin
            bcnt[i] = 0; seen_go[i] = 0; seen_kill[i] = 0;
        end
        forever begin
            @(negedge clk);
            a = ACK;
            e = ERR;
            #1;
            for (int i = 0; i < N; i++) begin
                if (go_cnt[i] != seen_go[i] || rearm[i]) begin
                    seen_go[i]  = go_cnt[i];
                    rearm[i]    = 1'b0;
                    err_seen[i] = 1'b0;
                    bcnt[i]     = 0;
                    CYC[i]      = 1'b1;
                    STB[i]      = 1'b1;
                end else if (kill_cnt[i] != seen_kill[i]) begin
                    seen_kill[i] = kill_cnt[i];
                    CYC[i] = 1'b0;
                    STB[i] = 1'b0;
                end else if (CYC[i] && a[i]) begin
                    bcnt[i]++;
                    if (bcnt[i] == beats[i]) begin
                        CYC[i] = 1'b0;
                        STB[i] = 1'b0;
                        if (reps[i] > 0) begin
                            reps[i]--;
                            rearm[i] = 1'b1;
                        end
                    end
                end else if (CYC[i] && e[i]) begin
                    err_seen[i] = 1'b1;
                end
                ADR[i]   = base[i] + 32'(4 * bcnt[i]);
                CTI[i]   = (beats[i] == 1) ? 3'b000 : ((bcnt[i] == beats[i] - 1) ? 3'b111 : 3'b010);
                DAT_W[i] = ~ADR[i];
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT grants, acks or errors.
    initial begin
        logic prev_gv;
        int   owner;
        int   ncyc;
        ev_t  ev;
        bit   ok;
        prev_gv = 1'b0;
        owner   = -1;
        ncyc    = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_gv = 1'b0;
                owner   = -1;
            end else begin
                ncyc++;
                if (gnt_valid && !prev_gv) begin
                    get_ev(ev, ok);
                    if (ok) begin
                        check("grant_order", 64'(EV_G * 16 + int'(gnt_id)), 64'(ev.kind * 16 + ev.id));
                        check("grant_sadr", 64'(SADR), 64'(ev.data));
                        owner = ev.id;
                    end
                    ncyc = 0;
                end
                if (!gnt_valid) owner = -1;
                for (int i = 0; i < N; i++) begin
                    if (ACK[i]) begin
                        get_ev(ev, ok);
                        if (ok) begin
                            check("ack_order", 64'(EV_A * 16 + i), 64'(ev.kind * 16 + ev.id));
                            check("ack_data", 64'(DAT_R[i]), 64'(ev.data));
                        end
                    end
                    if (ERR[i]) begin
                        get_ev(ev, ok);
                        if (ok) begin
                            check("err_order", 64'(EV_E * 16 + i), 64'(ev.kind * 16 + ev.id));
                            check("err_cycle", 64'(ncyc), 64'(ev.data));
                            check("err_timeout_scyc", {62'd0, timeout, SCYC}, 64'b10);
                        end
                    end
                end
                if (SACK || SERR) begin
                    for (int i = 0; i < N; i++)
                        if (i != owner)
                            check("idle_master_quiet", {30'd0, ACK[i], ERR[i], DAT_R[i]}, 64'd0);
                end
                prev_gv = gnt_valid;
            end
        end
    end

    task automatic wait_done(input int max);
        int t;
        t = 0;
        while ((q.size() != 0 || CYC != '0 || rearm != '0) && t < max) begin
            @(negedge clk);
            t++;
        end
        if (t >= max) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_done: %0d events still pending after %0d cycles, expected 0", q.size(), max);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst = 1'b1;
        @(negedge clk); #2;
        rst = 1'b0;
    endtask

    initial begin
        int t;
        for (int i = 0; i < N; i++) begin
            base[i] = '0; beats[i] = 1; reps[i] = 0; go_cnt[i] = 0; kill_cnt[i] = 0;
        end

        // Reset state
        @(negedge clk);
        check("reset_status", {61'd0, gnt_valid, gnt_id}, 64'd0);
        check("reset_bus", {59'd0, SCYC, SSTB, timeout, |ACK, |ERR}, 64'd0);
        check("reset_sadr", 64'(SADR), 64'd0);
        @(negedge clk); #2;
        rst = 1'b0;

        // 1: single access from master 2, one-cycle grant latency
        push(EV_G, 2, 32'h100);
        push(EV_A, 2, 32'h100 ^ KEY);
        start(2, 32'h100, 1, 0);
        @(negedge clk); #2;
        check("latency_before", {63'd0, SCYC}, 64'd0);
        @(negedge clk);
        check("latency_after", {63'd0, SCYC}, 64'd1);
        wait_done(50);

        // 2: round-robin across 0,1,3 from a fresh reset
        do_reset();
        for (int r = 0; r < 2; r++) begin
            push(EV_G, 0, 32'h10); push(EV_A, 0, 32'h10 ^ KEY);
            push(EV_G, 1, 32'h20); push(EV_A, 1, 32'h20 ^ KEY);
            push(EV_G, 3, 32'h30); push(EV_A, 3, 32'h30 ^ KEY);
        end
        start(0, 32'h10, 1, 1);
        start(1, 32'h20, 1, 1);
        start(3, 32'h30, 1, 1);
        wait_done(100);

        // 3: master 1 burst is not broken up by master 0
        push(EV_G, 1, 32'h1000);
        for (int b = 0; b < 4; b++) push(EV_A, 1, (32'h1000 + 32'(4 * b)) ^ KEY);
        push(EV_G, 0, 32'h2000);
        push(EV_A, 0, 32'h2000 ^ KEY);
        start(1, 32'h1000, 4, 0);
        @(negedge clk); @(negedge clk); #2;
        start(0, 32'h2000, 1, 0);
        wait_done(100);

        // 4: watchdog on a silent slave, grant held through drain
        ack_en = 1'b0;
        push(EV_G, 2, 32'h200);
        push(EV_E, 2, 32'(TO));
        start(2, 32'h200, 1, 0);
        t = 0;
        while (!err_seen[2] && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("watchdog_fired", {63'd0, err_seen[2]}, 64'd1);
        #1;
        push(EV_G, 3, 32'h300);
        push(EV_A, 3, 32'h300 ^ KEY);
        start(3, 32'h300, 1, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("drain_hold", {60'd0, gnt_valid, gnt_id, SCYC}, {60'd0, 1'b1, 2'd2, 1'b0});
            #2;
            late_ack = (c == 0);
        end
        late_ack = 1'b0;
        ack_en   = 1'b1;
        kill_cnt[2]++;
        wait_done(100);

        // 5: reset during an active grant restores master 0 priority
        push(EV_G, 0, 32'h40); push(EV_A, 0, 32'h40 ^ KEY);
        start(0, 32'h40, 1, 0);
        wait_done(50);
        ack_en = 1'b0;
        push(EV_G, 1, 32'h50);
        start(1, 32'h50, 1, 0);
        t = 0;
        while (!gnt_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk); #2;
        rst = 1'b1;
        kill_cnt[1]++;
        #1;
        check("rst_outputs", {57'd0, gnt_valid, gnt_id, SCYC, SSTB, timeout, |ACK | |ERR},
              64'd0);
        @(negedge clk); #2;
        rst    = 1'b0;
        ack_en = 1'b1;
        push(EV_G, 0, 32'h60); push(EV_A, 0, 32'h60 ^ KEY);
        push(EV_G, 3, 32'h70); push(EV_A, 3, 32'h70 ^ KEY);
        start(0, 32'h60, 1, 0);
        start(3, 32'h70, 1, 0);
        wait_done(100);

        check("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1);
    end

endmodule
